wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 172 +++++++++++++++++
 tb/tb_wb_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage -- write-back stage with integrated 32 x XLEN register file.
//
// Purpose: accepts one execute-stage result per cycle, selects the write-back
// value, holds it for one edge (pending entry) and then commits it to the
// register file while counting retired entries. After reset the register
// file is cleared by a sweep (x1..x31, one per cycle) before the stage
// starts accepting results. Reads are combinational and bypass the pending
// entry.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready execute-stage handshake (ready only once the sweep is done)
//   ex_out              {opr_res, rd, wb_en, wb_sel}
//   mem_rdata, pc_plus4 load data / link value, aligned with ex_out
//   flush               kills the pending entry and the incoming one
//   rs1_addr, rs2_addr  read addresses
//   rs1_data, rs2_data  read data (0 for x0 and while sweeping)
//   init_done           register-file clear sweep complete
//   instret             retired-entry count, wraps modulo 2^INSTRET_W

package wb_stage_pkg;
  typedef struct packed {
    logic [31:0] opr_res;
    logic [4:0]  rd;
    logic        wb_en;
    logic [1:0]  wb_sel;
  } ex_stage_out_t;
endpackage

module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  ex_stage_out_t        ex_out,
  input  logic [XLEN-1:0]      mem_rdata,
  input  logic [XLEN-1:0]      pc_plus4,
  input  logic                 flush,
  input  logic [4:0]           rs1_addr,
  input  logic [4:0]           rs2_addr,
  output logic [XLEN-1:0]      rs1_data,
  output logic [XLEN-1:0]      rs2_data,
  output logic                 init_done,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic [4:0]            r_init_idx;
  logic                  r_valid;
  logic [4:0]            r_rd;
  logic                  r_wb_en;
  logic [XLEN-1:0]       r_wdata;
  logic [INSTRET_W-1:0]  r_instret;
  logic [XLEN-1:0]       r_rf [0:31];

  logic                  w_cap, w_commit;
  logic [XLEN-1:0]       w_wdata_sel;
  logic                  w_rf_we;
  logic [4:0]            w_rf_waddr;
  logic [XLEN-1:0]       w_rf_wdata;
  logic [1:0][4:0]       w_raddr;
  logic [1:0][XLEN-1:0]  w_rdata;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_INIT;
    else     r_state <= w_state_nxt;
  end

  // Leave INIT the edge that clears x31.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_INIT && r_init_idx == 5'd31) w_state_nxt = S_RUN;
  end

  always_comb begin
    in_ready  = 1'b0;
    init_done = 1'b0;
    if (r_state == S_RUN) begin
      in_ready  = 1'b1;
      init_done = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            r_init_idx <= 5'd1;
    else if (r_state == S_INIT && r_init_idx != 5'd31)  r_init_idx <= r_init_idx + 5'd1;
  end

  // ---------------- capture / commit ----------------
  assign w_cap    = in_valid && in_ready && !flush;
  assign w_commit = r_valid && !flush;

  always_comb begin
    w_wdata_sel = '0;
    case (ex_out.wb_sel)
      2'b00:   w_wdata_sel = XLEN'(ex_out.opr_res);
      2'b01:   w_wdata_sel = mem_rdata;
      2'b10:   w_wdata_sel = pc_plus4;
      default: w_wdata_sel = '0;
    endcase
  end

  // Pending entry lives exactly one edge; no capture means it is gone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_rd    <= '0;
      r_wb_en <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_valid <= w_cap;
      if (w_cap) begin
        r_rd    <= ex_out.rd;
        r_wb_en <= ex_out.wb_en;
        r_wdata <= w_wdata_sel;
      end
    end
  end

  // Retire count advances even for entries that do not write a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_instret <= '0;
    else if (w_commit) r_instret <= r_instret + INSTRET_W'(1);
  end

  assign instret = r_instret;

  // ---------------- register file ----------------
  // Single write port shared by the clear sweep and commits; x0 is never written.
  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_waddr = r_rd;
    w_rf_wdata = r_wdata;
    if (r_state == S_INIT) begin
      w_rf_we    = 1'b1;
      w_rf_waddr = r_init_idx;
      w_rf_wdata = '0;
    end else if (w_commit && r_wb_en && r_rd != 5'd0) begin
      w_rf_we    = 1'b1;
    end
  end

  // Contents are deliberately not reset; the sweep clears them.
  always_ff @(posedge clk) begin
    if (w_rf_we) r_rf[w_rf_waddr] <= w_rf_wdata;
  end

  // ---------------- read ports ----------------
  assign w_raddr = {rs2_addr, rs1_addr};

  always_comb begin
    w_rdata = '0;
    for (int p = 0; p < 2; p++) begin
      if (r_state == S_RUN && w_raddr[p] != 5'd0) begin
        if (r_valid && r_wb_en && r_rd == w_raddr[p]) w_rdata[p] = r_wdata;
        else                                          w_rdata[p] = r_rf[w_raddr[p]];
      end
    end
  end

  assign rs1_data = w_rdata[0];
  assign rs2_data = w_rdata[1];

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, instret wrap,
// randomized traffic against a transaction-level model, and reset corners.
module tb_wb_stage;
  import wb_stage_pkg::*;

  localparam int XLEN = 32;
  localparam int IW   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  ex_stage_out_t   ex_out = '0;
  logic [31:0]     mem_rdata = '0;
  logic [31:0]     pc_plus4 = '0;
  logic            flush = 1'b0;
  logic [4:0]      rs1_addr = '0;
  logic [4:0]      rs2_addr = '0;
  logic [31:0]     rs1_data, rs2_data;
  logic            init_done;
  logic [IW-1:0]   instret;

  wb_stage #(.XLEN(XLEN), .INSTRET_W(IW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ex_out(ex_out), .mem_rdata(mem_rdata), .pc_plus4(pc_plus4), .flush(flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .init_done(init_done), .instret(instret)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // Architectural view: register array, a single in-flight entry, a retire count.
  logic [31:0] m_regs [32];
  int          m_init_left;
  bit          m_pv;
  logic [4:0]  m_prd;
  bit          m_pwe;
  logic [31:0] m_pdata;
  int          m_instret;

  task automatic m_reset();
    m_init_left = 31;
    m_pv        = 0;
    m_instret   = 0;
  endtask

  task automatic m_update();
    bit acc;
    if (rst) begin m_reset(); return; end
    if (m_init_left > 0) begin
      m_init_left--;
      if (m_init_left == 0) foreach (m_regs[i]) m_regs[i] = 32'h0;
      return;
    end
    acc = in_valid && !flush;
    if (m_pv && !flush) begin
      if (m_pwe && m_prd != 0) m_regs[m_prd] = m_pdata;
      m_instret = (m_instret + 1) % (1 << IW);
    end
    m_pv = acc;
    if (acc) begin
      m_prd = ex_out.rd;
      m_pwe = ex_out.wb_en;
      case (ex_out.wb_sel)
        2'd0:    m_pdata = ex_out.opr_res;
        2'd1:    m_pdata = mem_rdata;
        2'd2:    m_pdata = pc_plus4;
        default: m_pdata = 32'h0;
      endcase
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (m_init_left > 0 || a == 0) return 32'h0;
    if (m_pv && m_pwe && m_prd == a) return m_pdata;
    return m_regs[a];
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_update();
    #1;
  endtask

  // Counts edges until init_done, with inputs live to prove they are ignored.
  task automatic wait_init(input string name);
    int n = 0;
    in_valid = 1'b1;
    ex_out   = '{opr_res: 32'h5A5A5A5A, rd: 5'd5, wb_en: 1'b1, wb_sel: 2'd0};
    while (!init_done && n < 100) begin
      rs1_addr = 5'(n % 32);
      #1;
      chk({name, " ready_in_init"}, 32'(in_ready), 32'h0);
      chk({name, " rd_in_init"}, rs1_data, 32'h0);
      tick();
      n++;
    end
    in_valid = 1'b0;
    chk({name, " sweep_cycles"}, 32'(n), 32'd31);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v;
    logic [31:0] opr;
    logic [4:0]  rd;
    logic        we;
    logic [1:0]  sel;
    logic [31:0] mem;
    logic [31:0] pc4;
    logic        fl;
    logic [4:0]  ra;
    logic [31:0] exp_rd;
    logic [3:0]  exp_ir;
  } vec_t;

  vec_t tbl [14];

  initial begin
    foreach (m_regs[i]) m_regs[i] = 32'h0;
    m_reset();

    //            v  opr            rd  we sel mem            pc4           fl ra  exp_rd        ir
    tbl[0]  = '{1'b1, 32'h12345678, 5'd5, 1'b1, 2'd0, 32'h0,        32'h0,        1'b0, 5'd5, 32'h12345678, 4'd0};
    tbl[1]  = '{1'b0, 32'h0,        5'd0, 1'b0, 2'd0, 32'h0,        32'h0,        1'b0, 5'd5, 32'h12345678, 4'd1};
    tbl[2]  = '{1'b1, 32'h11111111, 5'd7, 1'b1, 2'd1, 32'hDEADBEEF, 32'h0,        1'b0, 5'd7, 32'hDEADBEEF, 4'd1};
    tbl[3]  = '{1'b1, 32'h22222222, 5'd7, 1'b1, 2'd2, 32'h33333333, 32'h00000104, 1'b0, 5'd7, 32'h00000104, 4'd2};
    tbl[4]  = '{1'b0, 32'h0,        5'd0, 1'b0, 2'd0, 32'h0,        32'h0,        1'b0, 5'd7, 32'h00000104, 4'd3};
    tbl[5]  = '{1'b1, 32'hFFFFFFFF, 5'd0, 1'b1, 2'd0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        4'd3};
    tbl[6]  = '{1'b0, 32'h0,        5'd0, 1'b0, 2'd0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        4'd4};
    tbl[7]  = '{1'b1, 32'h000000AA, 5'd3, 1'b1, 2'd0, 32'h0,        32'h0,        1'b0, 5'd3, 32'h000000AA, 4'd4};
    tbl[8]  = '{1'b0, 32'h0,        5'd0, 1'b0, 2'd0, 32'h0,        32'h0,        1'b1, 5'd3, 32'h0,        4'd4};
    tbl[9]  = '{1'b1, 32'h00000055, 5'd3, 1'b1, 2'd0, 32'h0,        32'h0,        1'b1, 5'd3, 32'h0,        4'd4};
    tbl[10] = '{1'b1, 32'h00000077, 5'd9, 1'b1, 2'd0, 32'h0,        32'h0,        1'b0, 5'd9, 32'h00000077, 4'd4};
    tbl[11] = '{1'b1, 32'h00000088, 5'd9, 1'b0, 2'd0, 32'h0,        32'h0,        1'b0, 5'd9, 32'h00000077, 4'd5};
    tbl[12] = '{1'b1, 32'h00000099, 5'd9, 1'b1, 2'd3, 32'h00000044, 32'h00000055, 1'b0, 5'd9, 32'h0,        4'd6};
    tbl[13] = '{1'b0, 32'h0,        5'd0, 1'b0, 2'd0, 32'h0,        32'h0,        1'b0, 5'd9, 32'h0,        4'd7};

    // ---- reset state ----
    tick(); tick();
    rs1_addr = 5'd5; rs2_addr = 5'd7; #1;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_init_done", 32'(init_done), 32'h0);
    chk("rst_instret", 32'(instret), 32'h0);
    chk("rst_rs1", rs1_data, 32'h0);
    chk("rst_rs2", rs2_data, 32'h0);
    rst = 1'b0;

    // ---- sweep after reset ----
    wait_init("init");
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a); rs2_addr = 5'(31 - a); #1;
      chk("post_init_rs1", rs1_data, 32'h0);
      chk("post_init_rs2", rs2_data, 32'h0);
    end
    chk("post_init_instret", 32'(instret), 32'h0);
    chk("post_init_ready", 32'(in_ready), 32'h1);

    // ---- directed table ----
    foreach (tbl[i]) begin
      in_valid      = tbl[i].v;
      ex_out        = '{opr_res: tbl[i].opr, rd: tbl[i].rd, wb_en: tbl[i].we, wb_sel: tbl[i].sel};
      mem_rdata     = tbl[i].mem;
      pc_plus4      = tbl[i].pc4;
      flush         = tbl[i].fl;
      rs1_addr      = tbl[i].ra;
      rs2_addr      = tbl[i].ra;
      tick();
      chk($sformatf("tbl%0d_rs1", i), rs1_data, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_rs2", i), rs2_data, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_instret", i), 32'(instret), 32'(tbl[i].exp_ir));
    end
    flush = 1'b0;

    // ---- instret wrap: 9 back-to-back captures then drain ----
    rs1_addr = 5'd10; rs2_addr = 5'd5;
    for (int k = 0; k < 9; k++) begin
      in_valid = 1'b1;
      ex_out   = '{opr_res: 32'h100 + 32'(k), rd: 5'd10, wb_en: 1'b1, wb_sel: 2'd0};
      tick();
      chk("b2b_bypass", rs1_data, 32'h100 + 32'(k));
    end
    chk("instret_all_ones", 32'(instret), 32'hF);
    in_valid = 1'b0;
    tick();
    chk("instret_wrap", 32'(instret), 32'h0);
    chk("wrap_x10", rs1_data, 32'h108);
    chk("wrap_x5", rs2_data, 32'h12345678);

    // ---- randomized traffic vs model ----
    for (int c = 0; c < 400; c++) begin
      in_valid         = ($urandom_range(0, 3) != 0);
      flush            = ($urandom_range(0, 9) == 0);
      ex_out.opr_res   = $urandom();
      ex_out.rd        = 5'($urandom_range(0, 7));
      ex_out.wb_en     = ($urandom_range(0, 4) != 0);
      ex_out.wb_sel    = 2'($urandom_range(0, 3));
      mem_rdata        = $urandom();
      pc_plus4         = $urandom();
      rs1_addr         = 5'($urandom_range(0, 7));
      rs2_addr         = 5'($urandom_range(0, 31));
      tick();
      chk("rnd_rs1", rs1_data, m_read(rs1_addr));
      chk("rnd_rs2", rs2_data, m_read(rs2_addr));
      chk("rnd_instret", 32'(instret), 32'(m_instret));
    end
    flush = 1'b0;

    // ---- reset mid-operation discards the pending entry ----
    in_valid = 1'b1;
    ex_out   = '{opr_res: 32'h0000CAFE, rd: 5'd12, wb_en: 1'b1, wb_sel: 2'd0};
    rs1_addr = 5'd12;
    tick();
    chk("pre_rst_bypass", rs1_data, 32'h0000CAFE);
    in_valid = 1'b0;
    rst = 1'b1; m_reset(); #1;
    chk("midop_rst_ready", 32'(in_ready), 32'h0);
    chk("midop_rst_done", 32'(init_done), 32'h0);
    chk("midop_rst_instret", 32'(instret), 32'h0);
    chk("midop_rst_rs1", rs1_data, 32'h0);
    tick();
    rst = 1'b0;
    wait_init("midop");
    rs1_addr = 5'd12; #1;
    chk("midop_x12_cleared", rs1_data, 32'h0);
    chk("midop_instret", 32'(instret), 32'h0);

    // ---- reset mid-sweep restarts the full sweep ----
    rst = 1'b1; m_reset(); #1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("midsweep_not_done", 32'(init_done), 32'h0);
    rst = 1'b1; m_reset(); #1;
    tick();
    rst = 1'b0;
    wait_init("midsweep");
    chk("midsweep_instret", 32'(instret), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
